// File: rtl/alu_scheduler_if.sv
// Bundle between two requesters, the scheduler, the shared ALU and the response sink.
// Combinational only (no state); latency and timing are set by the scheduler.
// Backpressure: req ready/valid toward requesters, resp valid/ready toward the sink.
// Ports: req0_*/req1_* operation requests, alu_* drive to the shared ALU and
//   alu_result back, resp_* single response channel, busy status.
// slave = scheduler side, master = environment side (requesters, ALU, sink).
interface alu_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_op;
  logic [5:0]  req0_n;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_op;
  logic [5:0]  req1_n;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [5:0]  alu_n;
  logic [31:0] alu_result;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_err;

  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_n,
    input  req1_valid, req1_a, req1_b, req1_op, req1_n,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op, alu_n,
    input  alu_result,
    output resp_valid, resp_id, resp_data, resp_err,
    input  resp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_n,
    output req1_valid, req1_a, req1_b, req1_op, req1_n,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op, alu_n,
    output alu_result,
    input  resp_valid, resp_id, resp_data, resp_err,
    output resp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_scheduler.sv
// Arbitrates two requesters onto one shared multi-cycle ALU, one op in flight.
// Latency: ready cycle T -> resp_valid from T+W+1 (W = FP_WAIT or LOGIC_WAIT), T+1 for illegal ops.
// Backpressure: response held until resp_ready; no request is accepted outside IDLE.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries both request
//   channels, the registered ALU drive plus alu_result, the response channel and busy.
// FP_WAIT and LOGIC_WAIT must both be at least 1.
module alu_scheduler #(
  parameter int FP_WAIT    = 3,
  parameter int LOGIC_WAIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_grant_q;
  logic [15:0] cnt_q;
  logic        resp_id_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_op_q;
  logic [5:0]  alu_n_q;

  logic        any_vld;
  logic        gnt_id;
  logic        accept;
  logic        gnt_legal;
  logic        gnt_fp;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [3:0]  sel_op;
  logic [5:0]  sel_n;

  // Grant: a lone requester wins; under contention the one not granted last wins.
  // rst_n gates accept so no ready is shown while reset is held.
  always_comb begin
    any_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = bus.req1_valid;
    end
    accept = (state_q == IDLE) && rst_n && any_vld;

    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    sel_op = bus.req0_op;
    sel_n  = bus.req0_n;
    if (gnt_id) begin
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
      sel_op = bus.req1_op;
      sel_n  = bus.req1_n;
    end
    gnt_legal = (sel_op <= 4'd10);
    gnt_fp    = (sel_op <= 4'd3);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = gnt_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (cnt_q == 16'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: ALU operands change only on acceptance so the ALU sees a stable
  // input for the whole wait; the result is sampled on the last EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cnt_q        <= 16'd0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_op_q     <= 4'd0;
      alu_n_q      <= 6'd0;
    end else if (accept) begin
      last_grant_q <= gnt_id;
      resp_id_q    <= gnt_id;
      alu_a_q      <= sel_a;
      alu_b_q      <= sel_b;
      alu_op_q     <= sel_op;
      alu_n_q      <= sel_n;
      if (gnt_legal) begin
        cnt_q <= gnt_fp ? 16'(FP_WAIT) : 16'(LOGIC_WAIT);
      end else begin
        cnt_q       <= 16'd0;
        resp_data_q <= 32'd0;
        resp_err_q  <= 1'b1;
      end
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q - 16'd1;
      if (cnt_q == 16'd1) begin
        resp_data_q <= bus.alu_result;
        resp_err_q  <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = accept & ~gnt_id;
  assign bus.req1_ready = accept & gnt_id;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_n      = alu_n_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler with a behavioural ALU on the alu_* port.
// Expected responses are queued at acceptance; a monitor compares them on resp_valid.
// Random phase exercises contention, abandonment and response backpressure.
module tb_alu_scheduler;
  localparam int FPW = 3;
  localparam int LGW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_scheduler_if ifc();

  alu_scheduler #(.FP_WAIT(FPW), .LOGIC_WAIT(LGW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          due;
    bit          seen;
  } exp_t;
  typedef struct {
    logic        id;
    logic [31:0] data;
  } log_t;

  exp_t sb[$];
  log_t resp_log[$];
  logic last_gnt = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Single-precision <-> real for normal numbers; denormals flush to zero.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          se;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    se = int'(d[62:52]) - 896;
    if (se <= 0) return {d[63], 31'd0};
    if (se >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], se[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op, input logic [5:0] n);
    case (op)
      4'd0:    return r2f(f2r(a) + f2r(b));
      4'd1:    return r2f(f2r(a) - f2r(b));
      4'd2:    return r2f(f2r(a) / f2r(b));
      4'd3:    return r2f(f2r(a) * f2r(b));
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~a;
      4'd7:    return a ^ b;
      4'd8:    return a << n;
      4'd9:    return a >> n;
      4'd10:   return $signed(a) >>> n;
      default: return 32'd0;
    endcase
  endfunction

  assign ifc.alu_result = alu_fn(ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.alu_n);

  // Acceptance model: idle means nothing outstanding in the scoreboard.
  always @(negedge clk) begin
    logic        fl, e0, e1, legal;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [5:0]  n;
    exp_t        e;
    fl = (sb.size() != 0);
    e0 = rst_n && !fl && ifc.req0_valid && (!ifc.req1_valid || last_gnt);
    e1 = rst_n && !fl && ifc.req1_valid && (!ifc.req0_valid || !last_gnt);
    check("req0_ready", 32'(ifc.req0_ready), 32'(e0));
    check("req1_ready", 32'(ifc.req1_ready), 32'(e1));
    check("busy", 32'(ifc.busy), 32'(fl));
    if (e0 || e1) begin
      op = e1 ? ifc.req1_op : ifc.req0_op;
      a  = e1 ? ifc.req1_a  : ifc.req0_a;
      b  = e1 ? ifc.req1_b  : ifc.req0_b;
      n  = e1 ? ifc.req1_n  : ifc.req0_n;
      legal  = (op <= 4'd10);
      e.id   = e1;
      e.data = legal ? alu_fn(a, b, op, n) : 32'd0;
      e.err  = !legal;
      e.due  = cyc + 1 + (legal ? ((op <= 4'd3) ? FPW : LGW) : 0);
      e.seen = 1'b0;
      sb.push_back(e);
      last_gnt = e1;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    log_t l;
    #1;
    if (sb.size() == 0) begin
      check("resp_valid_unexpected", 32'(ifc.resp_valid), 32'd0);
    end else begin
      if (!sb[0].seen) begin
        check("resp_valid_timing", 32'(ifc.resp_valid), 32'(cyc >= sb[0].due));
        if (ifc.resp_valid) sb[0].seen = 1'b1;
      end
      if (ifc.resp_valid) begin
        check("resp_id", 32'(ifc.resp_id), 32'(sb[0].id));
        check("resp_data", ifc.resp_data, sb[0].data);
        check("resp_err", 32'(ifc.resp_err), 32'(sb[0].err));
        if (ifc.resp_ready) begin
          l.id   = ifc.resp_id;
          l.data = ifc.resp_data;
          resp_log.push_back(l);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset_assert();
    rst_n = 1'b0;
    sb.delete();
    last_gnt = 1'b1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] n);
    if (k == 0) begin
      ifc.req0_valid = v; ifc.req0_op = op; ifc.req0_a = a; ifc.req0_b = b; ifc.req0_n = n;
    end else begin
      ifc.req1_valid = v; ifc.req1_op = op; ifc.req1_a = a; ifc.req1_b = b; ifc.req1_n = n;
    end
  endtask

  task automatic rand_req(output logic [3:0] op, output logic [31:0] a,
                          output logic [31:0] b, output logic [5:0] n);
    op = 4'($urandom_range(0, 15));
    a  = $urandom;
    b  = $urandom;
    n  = 6'($urandom_range(0, 63));
    if (op <= 4'd3) begin
      a = {a[31], 8'($urandom_range(120, 134)), a[22:0]};
      b = {b[31], 8'($urandom_range(120, 134)), b[22:0]};
    end
  endtask

  task automatic wait_grant(output int id, output int at);
    id = -1;
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.req0_valid && ifc.req0_ready) begin id = 0; at = cyc; break; end
      if (ifc.req1_valid && ifc.req1_ready) begin id = 1; at = cyc; break; end
    end
    if (id < 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (ifc.resp_valid) begin at = cyc; break; end
    end
    if (at < 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !ifc.busy) begin ok = 1'b1; break; end
    end
    check("idle_timeout", 32'(ok), 32'd1);
    tick(1);
  endtask

  initial begin
    int id, ta, tr;
    logic a0, a1;
    logic [3:0] op;
    logic [31:0] ra, rb;
    logic [5:0] rn;

    ifc.resp_ready = 1'b1;
    set_req(0, 1'b1, 4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 6'd0);
    set_req(1, 1'b1, 4'd5, 32'hFFFF0000, 32'h0F0F0F0F, 6'd0);
    do_reset_assert();
    #13;
    check("rst_req0_ready", 32'(ifc.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(ifc.req1_ready), 32'd0);
    check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    check("rst_resp_data", ifc.resp_data, 32'd0);
    check("rst_resp_id", 32'(ifc.resp_id), 32'd0);
    check("rst_resp_err", 32'(ifc.resp_err), 32'd0);
    check("rst_alu_a", ifc.alu_a, 32'd0);
    check("rst_alu_b", ifc.alu_b, 32'd0);
    check("rst_alu_op", 32'(ifc.alu_op), 32'd0);
    check("rst_alu_n", 32'(ifc.alu_n), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);

    // Contention from reset: req0 first, then strict alternation.
    tick(1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(id, ta);
      check("grant_order", id, k % 2);
    end
    tick(1);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    wait_idle();
    check("and_id", 32'(resp_log[0].id), 32'd0);
    check("and_data", resp_log[0].data, 32'h0F0F0000);
    check("or_id", 32'(resp_log[1].id), 32'd1);
    check("or_data", resp_log[1].data, 32'hFFFF0F0F);

    // FP ADD 1.0 + 2.0.
    set_req(0, 1'b1, 4'd0, 32'h3F800000, 32'h40000000, 6'd0);
    wait_grant(id, ta);
    tick(1);
    ifc.req0_valid = 1'b0;
    wait_valid(tr);
    check("add_latency", tr - ta, 32'd4);
    check("add_data", ifc.resp_data, 32'h40400000);
    check("add_id", 32'(ifc.resp_id), 32'd0);
    check("add_err", 32'(ifc.resp_err), 32'd0);
    wait_idle();

    // Illegal opcode.
    set_req(1, 1'b1, 4'hF, 32'h12345678, 32'h9ABCDEF0, 6'd3);
    wait_grant(id, ta);
    tick(1);
    ifc.req1_valid = 1'b0;
    wait_valid(tr);
    check("ill_latency", tr - ta, 32'd1);
    check("ill_err", 32'(ifc.resp_err), 32'd1);
    check("ill_data", ifc.resp_data, 32'd0);
    check("ill_id", 32'(ifc.resp_id), 32'd1);
    wait_idle();

    // SLL with response backpressure; req1 waits meanwhile.
    ifc.resp_ready = 1'b0;
    set_req(0, 1'b1, 4'd8, 32'h00000001, 32'h0, 6'd4);
    wait_grant(id, ta);
    tick(1);
    ifc.req0_valid = 1'b0;
    set_req(1, 1'b1, 4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 6'd0);
    wait_valid(tr);
    check("sll_latency", tr - ta, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(ifc.resp_valid), 32'd1);
      check("hold_data", ifc.resp_data, 32'h00000010);
      check("hold_busy", 32'(ifc.busy), 32'd1);
      check("hold_ready1", 32'(ifc.req1_ready), 32'd0);
      @(negedge clk);
      #2;
    end
    tick(1);
    ifc.resp_ready = 1'b1;
    wait_grant(id, ta);
    check("after_hold_grant", id, 32'd1);
    tick(1);
    ifc.req1_valid = 1'b0;
    wait_idle();

    // Reset during MUL execution discards it.
    set_req(0, 1'b1, 4'd3, 32'h40400000, 32'h40000000, 6'd0);
    wait_grant(id, ta);
    tick(1);
    ifc.req0_valid = 1'b0;
    tick(1);
    do_reset_assert();
    #1;
    check("mid_rst_busy", 32'(ifc.busy), 32'd0);
    check("mid_rst_valid", 32'(ifc.resp_valid), 32'd0);
    check("mid_rst_alu_a", ifc.alu_a, 32'd0);
    check("mid_rst_alu_op", 32'(ifc.alu_op), 32'd0);
    check("mid_rst_data", ifc.resp_data, 32'd0);
    tick(2);
    rst_n = 1'b1;
    resp_log.delete();
    set_req(1, 1'b1, 4'd7, 32'hA5A5A5A5, 32'hFFFF0000, 6'd0);
    wait_grant(id, ta);
    check("xor_grant", id, 32'd1);
    tick(1);
    ifc.req1_valid = 1'b0;
    wait_idle();
    check("xor_count", resp_log.size(), 32'd1);
    check("xor_data", resp_log[0].data, 32'h5A5AA5A5);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a0 = ifc.req0_valid & ifc.req0_ready;
      a1 = ifc.req1_valid & ifc.req1_ready;
      tick(1);
      if (i == 700) begin
        do_reset_assert();
        tick(1);
        rst_n = 1'b1;
      end
      if (a0 || (ifc.req0_valid && $urandom_range(0, 9) == 0)) begin
        ifc.req0_valid = 1'b0;
      end else if (!ifc.req0_valid && $urandom_range(0, 2) == 0) begin
        rand_req(op, ra, rb, rn);
        set_req(0, 1'b1, op, ra, rb, rn);
      end else if (ifc.req0_valid && $urandom_range(0, 4) == 0) begin
        rand_req(op, ra, rb, rn);
        set_req(0, 1'b1, op, ra, rb, rn);
      end
      if (a1 || (ifc.req1_valid && $urandom_range(0, 9) == 0)) begin
        ifc.req1_valid = 1'b0;
      end else if (!ifc.req1_valid && $urandom_range(0, 2) == 0) begin
        rand_req(op, ra, rb, rn);
        set_req(1, 1'b1, op, ra, rb, rn);
      end else if (ifc.req1_valid && $urandom_range(0, 4) == 0) begin
        rand_req(op, ra, rb, rn);
        set_req(1, 1'b1, op, ra, rb, rn);
      end
      ifc.resp_ready = ($urandom_range(0, 2) != 0);
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    ifc.resp_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end
endmodule
